// File: rtl/matrix_loader.sv
// matrix_loader: collects 16 fp32 words (column-major) into a shadow buffer, then
//    replays them to the vertex shader as four column strobes once the pipe is idle.
// Latency: the burst starts on the first edge with pipe_idle_in high after the 16th word;
//    strobes are spaced by GAP_CYCLES, and done_out pulses one cycle after the last strobe.
// Backpressure: word_ready_out is high only in FILL, so the stream stalls while a burst is pending.
//
// Ports:
//    clk_in, rst_n_in       clock, asynchronous active-low reset
//    word_valid_in/word_in  input word stream; word_ready_out accepts it
//    pipe_idle_in           shader reports no vertex in flight
//    col_set_out, col_out   column strobe and payload (lane i = row i)
//    busy_out, done_out     burst pending/active, end-of-burst pulse
//    ident_in               only with MATRIX_LOADER_IDENTITY_EN: load the identity matrix
//
// Optional feature macro: MATRIX_LOADER_IDENTITY_EN
module matrix_loader #(
   parameter int GAP_CYCLES = 0
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             word_valid_in,
   input  logic [31:0]      word_in,
   output logic             word_ready_out,
   input  logic             pipe_idle_in,
`ifdef MATRIX_LOADER_IDENTITY_EN
   input  logic             ident_in,
`endif
   output logic             col_set_out,
   output logic [3:0][31:0] col_out,
   output logic             busy_out,
   output logic             done_out
);

   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      FILL      = 2'd0,
      WAIT_IDLE = 2'd1,
      SEND      = 2'd2
   } state_t;

   state_t                r_state;
   logic [3:0]            r_cnt;      // next word slot: [3:2] column, [1:0] lane
   logic [1:0]            r_col;      // column most recently strobed
   logic [GW-1:0]         r_gap;      // idle cycles spent since the last strobe
   logic [3:0][3:0][31:0] r_buf;      // shadow buffer [column][lane]
   logic                  r_col_set;
   logic [3:0][31:0]      r_col_dat;
   logic                  r_done;

   logic                  w_fill;
   logic                  w_ident;
   logic                  w_hs;

`ifdef MATRIX_LOADER_IDENTITY_EN
   localparam logic [3:0][3:0][31:0] IDENTITY = '{
      '{32'h3F800000, 32'h0, 32'h0, 32'h0},   // column 3: lane 3 = 1.0
      '{32'h0, 32'h3F800000, 32'h0, 32'h0},   // column 2: lane 2 = 1.0
      '{32'h0, 32'h0, 32'h3F800000, 32'h0},   // column 1: lane 1 = 1.0
      '{32'h0, 32'h0, 32'h0, 32'h3F800000}    // column 0: lane 0 = 1.0
   };
   assign w_ident = ident_in;
`else
   assign w_ident = 1'b0;
`endif

   assign w_fill         = (r_state == FILL);
   // ident_in wins over a simultaneous word so the discarded partial fill stays discarded
   assign word_ready_out = w_fill & ~w_ident;
   assign w_hs           = word_valid_in & word_ready_out;

   assign busy_out    = ~w_fill;
   assign col_set_out = r_col_set;
   assign col_out     = r_col_dat;
   assign done_out    = r_done;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state   <= FILL;
         r_cnt     <= '0;
         r_col     <= '0;
         r_gap     <= '0;
         r_buf     <= '0;
         r_col_set <= 1'b0;
         r_col_dat <= '0;
         r_done    <= 1'b0;
      end else begin
         r_col_set <= 1'b0;
         r_done    <= 1'b0;
         case (r_state)
            FILL: begin
`ifdef MATRIX_LOADER_IDENTITY_EN
               if (w_ident) begin
                  r_buf   <= IDENTITY;
                  r_cnt   <= '0;
                  r_state <= WAIT_IDLE;
               end else
`endif
               if (w_hs) begin
                  r_buf[r_cnt[3:2]][r_cnt[1:0]] <= word_in;
                  r_cnt <= r_cnt + 4'd1;            // wraps to 0 on word 15
                  if (r_cnt == 4'd15) begin
                     r_state <= WAIT_IDLE;
                  end
               end
            end

            WAIT_IDLE: begin
               if (pipe_idle_in) begin
                  r_col_set <= 1'b1;
                  r_col_dat <= r_buf[0];
                  r_col     <= 2'd0;
                  r_gap     <= '0;
                  r_state   <= SEND;
               end
            end

            SEND: begin
               // pipe_idle_in is deliberately ignored: a started burst always completes
               if (r_col == 2'd3) begin
                  r_done  <= 1'b1;
                  r_col   <= 2'd0;
                  r_gap   <= '0;
                  r_state <= FILL;
               end else if (r_gap != GW'(GAP_CYCLES)) begin
                  r_gap <= r_gap + GW'(1);          // col_out holds the previous column
               end else begin
                  r_col_set <= 1'b1;
                  r_col_dat <= r_buf[r_col + 2'd1];
                  r_col     <= r_col + 2'd1;
                  r_gap     <= '0;
               end
            end

            default: r_state <= FILL;
         endcase
      end
   end

endmodule

// File: doc/matrix_loader.md
Name: matrix_loader

Overview:
- Producer end of the vertex shader's column-load interface.
- Accepts 16 fp32 matrix words over a valid/ready stream, in column-major order, into a shadow buffer.
- Waits until the vertex pipeline reports idle, then emits exactly four back-to-back col_set pulses (column 0..3).
- The shader's wrapping column index therefore always stays aligned.

Parameters:
- GAP_CYCLES, 0: number of idle (col_set low) cycles inserted between consecutive column pulses within a burst.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- word_valid_in  input  1  matrix word present
- word_in  input  32  fp32 matrix word
- word_ready_out  output  1  loader accepts a word this cycle
- pipe_idle_in  input  1  high when no vertex is in flight in the shader
- col_set_out  output  1  one-cycle column-write strobe to the shader
- col_out  output  4x32  column payload; lane i = row i
- busy_out  output  1  high in WAIT_IDLE and SEND
- done_out  output  1  one-cycle pulse after the fourth column is sent

Behaviour:
- Reset: the one clock is clk_in; rst_n_in is asynchronous and active-low.
- While rst_n_in is low:
  - state = FILL, word count = 0, column count = 0, gap counter = 0.
  - col_set_out = 0, col_out = 0, done_out = 0, busy_out = 0, shadow buffer = 0.
- Word mapping: the k-th accepted word (k = 0..15) is stored at column k/4, lane k%4.
- FILL:
  - word_ready_out = 1.
  - A handshake occurs on a rising edge with word_valid_in & word_ready_out; it stores the word and increments the count.
  - The handshake that stores word 15 sets count to 0 and moves to WAIT_IDLE.
  - A partial fill persists indefinitely; there is no timeout.
- WAIT_IDLE:
  - word_ready_out = 0, busy_out = 1.
  - On an edge where pipe_idle_in = 1: register col_set_out = 1 and col_out = column 0, then go to SEND.
- SEND:
  - Emits columns 1..3.
  - Each column strobe is preceded by GAP_CYCLES cycles with col_set_out = 0; col_out holds the last column during gaps.
  - Once SEND is entered, all four columns are always sent, even if pipe_idle_in drops. No partial bursts.
- After column 3's strobe cycle:
  - col_set_out = 0, done_out = 1 for exactly one cycle, busy_out = 0.
  - Return to FILL; word_ready_out = 1 from that cycle.
- Timing (GAP_CYCLES = 0, pipe_idle_in high): word 15 handshake at edge E.
  - col_set_out is high in the four cycles after edges E+1..E+4.
  - done_out is high after E+5; the next word can be accepted at E+6.
- Total burst length: 4 + 3·GAP_CYCLES strobe/gap cycles.
- col_set_out is never high for more than one cycle per column.
- Word data is not interpreted; values are passed bit-exact (NaN/Inf/denormals unchanged).
- Reset mid-burst: outputs drop asynchronously and the burst is lost. The system must reset the shader in the same event so its column index realigns to 0.

Optional Feature:
- Macro: MATRIX_LOADER_IDENTITY_EN
- Defined: adds input port ident_in (1 bit).
  - If ident_in = 1 in FILL: the shadow buffer is overwritten with identity (1.0 = 32'h3F800000 at column j lane j, 0 elsewhere), word count is cleared (partial fill discarded), and the state moves to WAIT_IDLE.
  - While ident_in = 1, word_ready_out is forced to 0 combinationally, so no word is accepted that cycle.
  - ident_in is ignored outside FILL.
- Undefined: no ident_in port; the identity matrix is only reachable by streaming its 16 words.

Test Plan:
- Stream words 0x00000001..0x00000010 with pipe_idle_in = 1, GAP_CYCLES = 0:
  - Four consecutive col_set_out cycles; column 0 = {lane0 = 1, lane1 = 2, lane2 = 3, lane3 = 4} … column 3 = {13, 14, 15, 16}.
  - done_out pulses once, one cycle after the last strobe; word_ready_out returns high.
- Hold pipe_idle_in = 0 for 20 cycles after word 15:
  - busy_out = 1, word_ready_out = 0, col_set_out = 0 throughout.
  - The burst starts on the first edge after pipe_idle_in rises.
- Drop pipe_idle_in during SEND after column 1: columns 2 and 3 are still emitted on schedule.
- GAP_CYCLES = 2:
  - Strobe pattern 1,0,0,1,0,0,1,0,0,1.
  - col_out stable through gaps; done_out after the final strobe.
- Deassert rst_n_in after word 9 and mid-SEND:
  - All outputs go to 0 immediately.
  - After release, 16 fresh words are required before any col_set_out.
- With MATRIX_LOADER_IDENTITY_EN, pulse ident_in after 5 words with word_valid_in also high:
  - That word is not accepted.
  - The burst emits identity columns (column j lane j = 32'h3F800000).
  - The next matrix needs a full 16 words.
